// File: rtl/piso_transmitter.sv
// piso_transmitter
//   Parallel-in serial-out transmitter. A WIDTH-bit word is accepted over a
//   load/ready handshake and shifted out one bit per clock on serial_out. frame
//   marks every valid data bit, and done pulses on the last bit of each word.
//   Back-to-back words stream with no idle gap.
//
// Parameters
//   WIDTH      data word width in bits (2..32)
//   MSB_FIRST  1: data_in[WIDTH-1] is sent first, 0: data_in[0] is sent first
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-high reset, highest priority
//   load        word-valid request, sampled on the rising edge
//   data_in     parallel word, captured on the edge where load && ready
//   ready       combinational; the block can accept a word this cycle
//   serial_out  registered current transmitted bit
//   frame       registered; high while serial_out carries a data bit
//   done        registered; one-cycle pulse on the last bit of a word
module piso_transmitter #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             serial_out,
    output logic             frame,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q,      state_d;
    logic [WIDTH-1:0] shreg_q,      shreg_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             serial_out_q, serial_out_d;
    logic             frame_q,      frame_d;
    logic             done_q,       done_d;

    logic last_bit;
    logic accept;

    // The last bit of a word is on serial_out this cycle.
    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_IDX);

    // Ready is forced low while reset is applied so no accept can race it.
    assign ready  = !reset && ((state_q == IDLE) || last_bit);
    assign accept = load && ready;

    // Next-state, shift-register and output computation.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        serial_out_d = 1'b0;
        frame_d      = 1'b0;
        done_d       = 1'b0;

        if (accept) begin
            // The first bit goes straight to serial_out; the register keeps
            // the remaining bits already aligned for the next shift.
            state_d = SHIFT;
            cnt_d   = '0;
            frame_d = 1'b1;
            if (MSB_FIRST) begin
                serial_out_d = data_in[WIDTH-1];
                shreg_d      = {data_in[WIDTH-2:0], 1'b0};
            end else begin
                serial_out_d = data_in[0];
                shreg_d      = {1'b0, data_in[WIDTH-1:1]};
            end
        end else if (state_q == SHIFT) begin
            if (last_bit) begin
                state_d = IDLE;
                cnt_d   = '0;
                shreg_d = '0;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
                frame_d = 1'b1;
                done_d  = ((cnt_q + CNT_W'(1)) == LAST_IDX);
                if (MSB_FIRST) begin
                    serial_out_d = shreg_q[WIDTH-1];
                    shreg_d      = {shreg_q[WIDTH-2:0], 1'b0};
                end else begin
                    serial_out_d = shreg_q[0];
                    shreg_d      = {1'b0, shreg_q[WIDTH-1:1]};
                end
            end
        end
    end

    // State and output registers; reset aborts any word in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            serial_out_q <= 1'b0;
            frame_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            serial_out_q <= serial_out_d;
            frame_q      <= frame_d;
            done_q       <= done_d;
        end
    end

    assign serial_out = serial_out_q;
    assign frame      = frame_q;
    assign done       = done_q;

endmodule

// File: tb/tb_piso_transmitter.sv
// Testbench for piso_transmitter: a WIDTH=4 MSB-first instance and a WIDTH=8
// LSB-first instance. Expected bits are queued at each accept and a negedge
// monitor pops and compares them against serial_out/frame/done.
module tb_piso_transmitter;

    typedef struct packed {
        logic bit_v;
        logic last;
    } exp_t;

    logic       clk;
    logic       rst4, load4, ready4, so4, frame4, done4;
    logic [3:0] data4;
    logic       rst8, load8, ready8, so8, frame8, done8;
    logic [7:0] data8;

    int   checks;
    int   errors;
    int   done4_cnt;
    int   done8_cnt;
    bit   mon_en;
    exp_t q4[$];
    exp_t q8[$];
    exp_t e4;
    exp_t e8;

    piso_transmitter #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut4 (
        .clk(clk), .reset(rst4), .load(load4), .data_in(data4),
        .ready(ready4), .serial_out(so4), .frame(frame4), .done(done4)
    );

    piso_transmitter #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut8 (
        .clk(clk), .reset(rst8), .load(load8), .data_in(data8),
        .ready(ready8), .serial_out(so8), .frame(frame8), .done(done8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: transmit order and last-bit marker per word.
    function automatic void push4(input logic [3:0] d);
        for (int i = 0; i < 4; i++) q4.push_back('{bit_v: d[3-i], last: (i == 3)});
    endfunction

    function automatic void push8(input logic [7:0] d);
        for (int i = 0; i < 8; i++) q8.push_back('{bit_v: d[i], last: (i == 7)});
    endfunction

    // Scoreboard monitors: a pending expected bit means frame must be high.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (q4.size() != 0) begin
                e4 = q4.pop_front();
                if ({frame4, so4, done4} !== {1'b1, e4.bit_v, e4.last}) begin
                    errors++;
                    $display("FAIL dut4_bit: frame/so/done=%b%b%b expected 1%b%b at %0t",
                             frame4, so4, done4, e4.bit_v, e4.last, $time);
                end
            end else if ({frame4, so4, done4} !== 3'b000) begin
                errors++;
                $display("FAIL dut4_idle: frame/so/done=%b%b%b expected 000 at %0t",
                         frame4, so4, done4, $time);
            end
            if (done4 === 1'b1) done4_cnt++;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (q8.size() != 0) begin
                e8 = q8.pop_front();
                if ({frame8, so8, done8} !== {1'b1, e8.bit_v, e8.last}) begin
                    errors++;
                    $display("FAIL dut8_bit: frame/so/done=%b%b%b expected 1%b%b at %0t",
                             frame8, so8, done8, e8.bit_v, e8.last, $time);
                end
            end else if ({frame8, so8, done8} !== 3'b000) begin
                errors++;
                $display("FAIL dut8_idle: frame/so/done=%b%b%b expected 000 at %0t",
                         frame8, so8, done8, $time);
            end
            if (done8 === 1'b1) done8_cnt++;
        end
    end

    task automatic test_reset();
        rst4 = 1'b1; rst8 = 1'b1; load4 = 1'b0; load8 = 1'b0;
        data4 = '0; data8 = '0;
        tick();
        tick();
        mon_en = 1'b1;
        checks++;
        if ({ready4, ready8} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready_low: ready4/ready8=%b%b expected 00", ready4, ready8);
        end
        checks++;
        if ({frame4, so4, done4, frame8, so8, done8} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: %b%b%b %b%b%b expected all 0",
                     frame4, so4, done4, frame8, so8, done8);
        end
        rst4 = 1'b0; rst8 = 1'b0;
        #1;
        checks++;
        if ({ready4, ready8} !== 2'b11) begin
            errors++;
            $display("FAIL reset_ready_idle: ready4/ready8=%b%b expected 11", ready4, ready8);
        end
    endtask

    task automatic test_single();
        int d0;
        d0 = done4_cnt;
        data4 = 4'b1010; load4 = 1'b1;
        tick();
        push4(4'b1010);
        load4 = 1'b0; data4 = 4'hF;
        tick(); tick(); tick();
        checks++;
        if (ready4 !== 1'b1) begin
            errors++;
            $display("FAIL single_ready_last: ready4=%b expected 1", ready4);
        end
        tick();
        checks++;
        if ({ready4, frame4} !== 2'b10) begin
            errors++;
            $display("FAIL single_after: ready/frame=%b%b expected 10", ready4, frame4);
        end
        tick();
        checks++;
        if (done4_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL single_done_count: %0d expected 1", done4_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done4_cnt;
        data4 = 4'b1010; load4 = 1'b1;
        tick();
        push4(4'b1010);
        load4 = 1'b0;
        tick(); tick(); tick();
        load4 = 1'b1; data4 = 4'b0101;
        #1;
        checks++;
        if (ready4 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: ready4=%b expected 1", ready4);
        end
        tick();
        push4(4'b0101);
        load4 = 1'b0;
        tick(); tick(); tick();
        tick();
        tick();
        checks++;
        if (done4_cnt - d0 !== 2) begin
            errors++;
            $display("FAIL b2b_done_count: %0d expected 2", done4_cnt - d0);
        end
    endtask

    task automatic test_busy();
        data4 = 4'b1100; load4 = 1'b1;
        tick();
        push4(4'b1100);
        load4 = 1'b0;
        tick();
        load4 = 1'b1; data4 = 4'b0011;
        #1;
        checks++;
        if (ready4 !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready: ready4=%b expected 0", ready4);
        end
        tick();
        load4 = 1'b0;
        tick(); tick();
        tick(); tick(); tick();
        checks++;
        if (frame4 !== 1'b0) begin
            errors++;
            $display("FAIL busy_no_second_frame: frame4=%b expected 0", frame4);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = done4_cnt;
        data4 = 4'b1111; load4 = 1'b1;
        tick();
        push4(4'b1111);
        load4 = 1'b0;
        tick();
        rst4 = 1'b1;
        #1;
        checks++;
        if (ready4 !== 1'b0) begin
            errors++;
            $display("FAIL mid_ready_in_reset: ready4=%b expected 0", ready4);
        end
        tick();
        q4.delete();
        checks++;
        if ({frame4, so4, done4} !== 3'b000) begin
            errors++;
            $display("FAIL mid_abort: frame/so/done=%b%b%b expected 000", frame4, so4, done4);
        end
        rst4 = 1'b0;
        #1;
        checks++;
        if (ready4 !== 1'b1) begin
            errors++;
            $display("FAIL mid_ready_after: ready4=%b expected 1", ready4);
        end
        tick(); tick(); tick(); tick();
        checks++;
        if (done4_cnt - d0 !== 0) begin
            errors++;
            $display("FAIL mid_done_count: %0d expected 0", done4_cnt - d0);
        end
    endtask

    task automatic test_lsb_first();
        int d0;
        d0 = done8_cnt;
        data8 = 8'hA5; load8 = 1'b1;
        tick();
        push8(8'hA5);
        load8 = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if ({done8, ready8} !== 2'b11) begin
            errors++;
            $display("FAIL lsb_last: done8/ready8=%b%b expected 11", done8, ready8);
        end
        tick();
        tick();
        checks++;
        if (done8_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL lsb_done_count: %0d expected 1", done8_cnt - d0);
        end
    endtask

    task automatic test_load_in_reset();
        rst4 = 1'b1; load4 = 1'b1; data4 = 4'b0110;
        #1;
        checks++;
        if (ready4 !== 1'b0) begin
            errors++;
            $display("FAIL lir_ready: ready4=%b expected 0", ready4);
        end
        tick();
        tick();
        checks++;
        if (frame4 !== 1'b0) begin
            errors++;
            $display("FAIL lir_frame_in_reset: frame4=%b expected 0", frame4);
        end
        rst4 = 1'b0;
        #1;
        checks++;
        if (ready4 !== 1'b1) begin
            errors++;
            $display("FAIL lir_ready_after: ready4=%b expected 1", ready4);
        end
        tick();
        push4(4'b0110);
        load4 = 1'b0;
        checks++;
        if ({frame4, so4} !== 2'b10) begin
            errors++;
            $display("FAIL lir_first_bit: frame/so=%b%b expected 10", frame4, so4);
        end
        tick(); tick(); tick();
        tick(); tick();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        done4_cnt = 0;
        done8_cnt = 0;
        mon_en    = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_busy();
        test_reset_mid();
        test_lsb_first();
        test_load_in_reset();
        checks++;
        if (q4.size() != 0 || q8.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: q4=%0d q8=%0d expected 0 0", q4.size(), q8.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
